// File: rtl/rr_lane_dispatcher.sv
// Buffers one valid/ready stream in a small FIFO and deals the words out to
// NUM_LANES child lanes in strict round-robin order, holding on a stalled lane.
module rr_lane_dispatcher #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned NUM_LANES  = 5,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16,
  localparam int unsigned LaneW     = $clog2(NUM_LANES),
  localparam int unsigned AddrW     = $clog2(FIFO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  output logic [NUM_LANES-1:0] out_valid,
  input  logic [NUM_LANES-1:0] out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic [LaneW-1:0]     lane_ptr,
  output logic [AddrW:0]       fifo_level,
  output logic [CNT_W-1:0]     dispatch_count
);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AddrW:0]    wr_ptr_q, wr_ptr_d;
  logic [AddrW:0]    rd_ptr_q, rd_ptr_d;
  logic [LaneW-1:0]  lane_ptr_q, lane_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full, empty, push, pop;

  always_comb begin
    empty      = (wr_ptr_q == rd_ptr_q);
    // Extra pointer MSB differs only when the write side has lapped the read side.
    full       = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                 (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    in_ready   = !full && !rst && !flush;
    push       = in_valid && in_ready;
    out_valid  = (!empty && !rst) ? (NUM_LANES'(1) << lane_ptr_q) : '0;
    pop        = !empty && !rst && !flush && out_ready[lane_ptr_q];
    out_data   = mem_q[rd_ptr_q[AddrW-1:0]];
    lane_ptr   = lane_ptr_q;
    fifo_level = wr_ptr_q - rd_ptr_q;
    dispatch_count = count_q;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q + (AddrW+1)'(push);
    rd_ptr_d   = rd_ptr_q + (AddrW+1)'(pop);
    count_d    = count_q + CNT_W'(pop);
    lane_ptr_d = lane_ptr_q;
    if (pop) begin
      lane_ptr_d = (lane_ptr_q == LaneW'(NUM_LANES - 1)) ? '0 : lane_ptr_q + LaneW'(1);
    end
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      lane_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      lane_ptr_q <= '0;
      count_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      lane_ptr_q <= lane_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: contents are only observed through valid pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= in_data;
    end
  end

  a_valid_onehot0: assert property (@(posedge clk) $onehot0(out_valid));
  a_level_bound:   assert property (@(posedge clk) disable iff (rst)
                                    fifo_level <= (AddrW+1)'(FIFO_DEPTH));
  a_no_overflow:   assert property (@(posedge clk) disable iff (rst) !(full && push));
  a_no_underflow:  assert property (@(posedge clk) disable iff (rst) !(empty && pop));

endmodule

// File: tb/tb_rr_lane_dispatcher.sv
// Directed bench for rr_lane_dispatcher: rotation, backpressure, stall hold,
// concurrent push/pop, reset mid-run and flush.
module tb_rr_lane_dispatcher;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [15:0] in_data, out_data, dispatch_count;
  logic [4:0]  out_valid, out_ready;
  logic [2:0]  lane_ptr, fifo_level;

  int n_checks = 0;
  int n_pass   = 0;
  int mon_lane[$];
  logic [15:0] mon_data[$];

  rr_lane_dispatcher dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .lane_ptr       (lane_ptr),
    .fifo_level     (fifo_level),
    .dispatch_count (dispatch_count)
  );

  always #5 clk = ~clk;

  // Log every completed output handshake as seen at the clock edge.
  always @(posedge clk) begin
    if (!flush) begin
      for (int i = 0; i < 5; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          mon_lane.push_back(i);
          mon_data.push_back(out_data);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic send(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic chk_log(input string tag, input int idx, input int lane, input logic [15:0] d);
    if (idx < mon_lane.size()) chk(tag, {mon_lane[idx][7:0], mon_data[idx]}, {lane[7:0], d});
    else chk(tag, 32'(mon_lane.size()), 32'(idx + 1));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = '0;
    #1;
    cyc(); cyc();
    settle();
    chk("rst_in_ready",  32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_level",     32'(fifo_level), 32'd0);
    chk("rst_lane",      32'(lane_ptr), 32'd0);
    chk("rst_count",     32'(dispatch_count), 32'd0);
    rst = 1'b0;
    settle();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Rotation: 7 words over 5 lanes
    out_ready = 5'b11111;
    for (int i = 0; i < 7; i++) send(16'(i + 1));
    repeat (4) cyc();
    settle();
    chk("rot_log_size", 32'(mon_lane.size()), 32'd7);
    chk_log("rot_w1", 0, 0, 16'h0001);
    chk_log("rot_w2", 1, 1, 16'h0002);
    chk_log("rot_w3", 2, 2, 16'h0003);
    chk_log("rot_w4", 3, 3, 16'h0004);
    chk_log("rot_w5", 4, 4, 16'h0005);
    chk_log("rot_w6", 5, 0, 16'h0006);
    chk_log("rot_w7", 6, 1, 16'h0007);
    chk("rot_count", 32'(dispatch_count), 32'd7);
    chk("rot_lane",  32'(lane_ptr), 32'd2);

    // Backpressure: realign to lane 0, then fill with all lanes stalled
    flush = 1'b1; cyc(); flush = 1'b0;
    out_ready = 5'b00000;
    mon_lane.delete(); mon_data.delete();
    for (int i = 0; i < 6; i++) send(16'(i + 1));
    settle();
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_level",    32'(fifo_level), 32'd4);
    chk("bp_valid",    32'(out_valid), 32'h01);
    chk("bp_data",     32'(out_data), 32'h0001);
    out_ready = 5'b00001;
    settle();
    chk("bp_full_pop_in_ready", 32'(in_ready), 32'd0);
    cyc(); settle();
    chk("bp_pop_level", 32'(fifo_level), 32'd3);
    chk("bp_pop_valid", 32'(out_valid), 32'h02);
    chk("bp_pop_data",  32'(out_data), 32'h0002);
    chk("bp_pop_count", 32'(dispatch_count), 32'd8);
    repeat (3) cyc();
    settle();
    chk("bp_hold_level", 32'(fifo_level), 32'd3);
    chk("bp_hold_valid", 32'(out_valid), 32'h02);
    chk("bp_hold_lane",  32'(lane_ptr), 32'd1);
    chk("bp_log_size",   32'(mon_lane.size()), 32'd1);
    chk_log("bp_w1", 0, 0, 16'h0001);

    // Stall hold on lane 2 with spurious ready on lane 3
    out_ready = 5'b00010;
    cyc();
    for (int i = 0; i < 10; i++) begin
      out_ready = (i % 2 == 1) ? 5'b01000 : 5'b00000;
      settle();
      chk("stall_valid", 32'(out_valid), 32'h04);
      chk("stall_data",  32'(out_data), 32'h0003);
      cyc();
    end
    settle();
    chk("stall_lane",  32'(lane_ptr), 32'd2);
    chk("stall_count", 32'(dispatch_count), 32'd9);
    chk("stall_level", 32'(fifo_level), 32'd2);

    // Concurrent push/pop at level 2
    mon_lane.delete(); mon_data.delete();
    out_ready = 5'b11111;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h0100 + 16'(i);
      settle();
      chk("pp_level", 32'(fifo_level), 32'd2);
      cyc();
    end
    in_valid = 1'b0; out_ready = 5'b00000;
    settle();
    chk("pp_log_size", 32'(mon_lane.size()), 32'd20);
    chk_log("pp_w0", 0, 2, 16'h0003);
    chk_log("pp_w1", 1, 3, 16'h0004);
    for (int k = 2; k < 20; k++) chk_log("pp_wk", k, (2 + k) % 5, 16'h0100 + 16'(k - 2));
    chk("pp_count", 32'(dispatch_count), 32'd29);
    chk("pp_lane",  32'(lane_ptr), 32'd2);
    chk("pp_level_end", 32'(fifo_level), 32'd2);

    // Reset mid-run with three words buffered and every lane ready
    send(16'h0AAA);
    settle();
    chk("mr_level_pre", 32'(fifo_level), 32'd3);
    mon_lane.delete(); mon_data.delete();
    out_ready = 5'b11111;
    rst = 1'b1;
    settle();
    chk("mr_in_ready_rst", 32'(in_ready), 32'd0);
    cyc(); settle();
    chk("mr_level", 32'(fifo_level), 32'd0);
    chk("mr_lane",  32'(lane_ptr), 32'd0);
    chk("mr_count", 32'(dispatch_count), 32'd0);
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_no_handshake", 32'(mon_lane.size()), 32'd0);
    rst = 1'b0;
    send(16'hBEEF);
    repeat (3) cyc();
    chk("mr_log_size", 32'(mon_lane.size()), 32'd1);
    chk_log("mr_first", 0, 0, 16'hBEEF);
    chk("mr_count_after", 32'(dispatch_count), 32'd1);

    // Flush at level 3, lane 3, count 8
    for (int i = 0; i < 7; i++) send(16'h0200 + 16'(i));
    repeat (3) cyc();
    out_ready = 5'b00000;
    for (int i = 0; i < 3; i++) send(16'h0300 + 16'(i));
    settle();
    chk("fl_level_pre", 32'(fifo_level), 32'd3);
    chk("fl_lane_pre",  32'(lane_ptr), 32'd3);
    chk("fl_count_pre", 32'(dispatch_count), 32'd8);
    flush = 1'b1; in_valid = 1'b1; in_data = 16'hDEAD; out_ready = 5'b11111;
    cyc();
    flush = 1'b0; in_valid = 1'b0; out_ready = 5'b00000;
    settle();
    chk("fl_level", 32'(fifo_level), 32'd0);
    chk("fl_lane",  32'(lane_ptr), 32'd0);
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_count", 32'(dispatch_count), 32'd8);
    cyc(); settle();
    chk("fl_level_later", 32'(fifo_level), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
